piece_queue: RTL
================

Name: piece_queue

Overview:
- Consumer end of the random piece generator path.
- Samples the 5-bit piece code stream every clock and filters out invalid codes and immediate repeats.
- Buffers accepted pieces in a small FIFO and hands them to the game FSM on a pop request.
- Exposes the current piece and a one-piece preview for the "next" display.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- MAX_REROLL, 1, number of consecutive repeat-rejections allowed before a repeat is accepted.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- rand_piece  in  5  piece code from generator, sampled every cycle.
- pop  in  1  game FSM takes the current piece; sampled at the rising edge.
- piece  out  5  head-of-queue piece code; 0 when empty.
- piece_valid  out  1  queue holds at least one piece.
- preview  out  5  second entry; 0 when count < 2.
- preview_valid  out  1  count >= 2.
- count  out  clog2(DEPTH)+1  number of stored pieces.
- full  out  1  count == DEPTH.

Behaviour:
- Reset state: reset low clears FIFO, pointers, count, last-code register, reroll counter and all outputs to 0, immediately (asynchronous). Leaving reset: the first sample is on the first rising edge with reset high.
- Valid codes: 1, 3, 7, 11, 12, 14, 18.
  - Any other value, including 0, is rejected.
  - A rejected invalid code does not touch the reroll counter.
- Candidate acceptance, evaluated every cycle on rand_piece:
  - Code invalid -> reject.
  - Code equals last accepted code and reroll_cnt < MAX_REROLL -> reject; reroll_cnt += 1.
  - Otherwise -> accept; reroll_cnt <= 0; last <= code.
  - After reset, "last" is 0, so no code counts as a repeat.
- Push: an accepted candidate is written at the tail when there is space after this cycle's pop, i.e. (count < DEPTH) or a pop happens this cycle.
  - If there is no space, the candidate is discarded.
  - Discarding leaves last and reroll_cnt unchanged: evaluation is gated by space.
- Pop: pop=1 with piece_valid=1 advances the head at that edge. pop with count==0 is ignored, with no error and no state change.
- Simultaneous pop and push in the same cycle:
  - count unchanged.
  - The new entry lands at the tail.
  - Head advances.
  - Full stays full.
  - Push into a full queue is permitted only in this case.
- Count update: count' = count + push - pop_eff, where pop_eff = pop & piece_valid.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH.
- Outputs: registered-path reads of the FIFO.
  - piece, preview, piece_valid, preview_valid, count and full reflect the state after the edge.
  - Latency from pop edge to next piece visible on piece: 0 extra cycles (valid right after the edge).
  - Latency from an accepted sample to visible on piece when empty: 1 edge.
- Invariant: no two adjacent FIFO entries are equal when MAX_REROLL >= 1, except after MAX_REROLL+1 consecutive identical valid candidates.
- Reset asserted mid-operation clears everything regardless of pop or push in flight.

Test Plan:
- Reset and fill:
  - Stimulus: hold reset=0 for 3 cycles, then release; drive rand_piece 3, 7, 11, 12 on successive edges.
  - Required: all outputs 0 during reset; after edge 1 piece=3, piece_valid=1, count=1; after edge 4 count=4, full=1, piece=3, preview=7.
- Invalid and repeat filtering:
  - Stimulus: from empty, drive 14, 0, 5, 14, 14, 18.
  - Required: 0 and 5 rejected; first repeat 14 rejected; second 14 accepted (MAX_REROLL=1); 18 accepted; FIFO contents 14, 14, 18 with count=3.
- Full discard:
  - Stimulus: queue full (3, 7, 11, 12), pop=0, drive 1 for 5 cycles.
  - Required: count stays 4, contents unchanged, last stays 12.
  - Then pop=1 for one cycle while rand_piece=1: piece=7, tail entry=1, count=4.
- Pop on empty:
  - Stimulus: after reset, rand_piece=0, pulse pop.
  - Required: count=0, piece=0, piece_valid=0, pointers unchanged.
- Drain and wrap:
  - Stimulus: fill with 1, 3, 7, 11, then rand_piece=0 with pop held high for 4 cycles.
  - Required: piece sequence 1, 3, 7, 11, then piece_valid=0.
  - Then refill with 12, 14, 18, 1: ordering correct across pointer wrap; preview tracks second entry each cycle.
- Reset mid-operation:
  - Stimulus: count=3, assert reset low between edges simultaneous with pop=1.
  - Required: outputs 0 immediately (asynchronous), no pop applied.
  - After release, rand_piece equal to the pre-reset last code is accepted, since last was cleared.

Source files
------------

// File: rtl/piece_queue.sv
// rtl/piece_queue.sv - filtered piece FIFO with current/preview outputs
module piece_queue #(
  parameter int DEPTH      = 4,
  parameter int MAX_REROLL = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             rand_piece,
  input  logic                   pop,
  output logic [4:0]             piece,
  output logic                   piece_valid,
  output logic [4:0]             preview,
  output logic                   preview_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Reroll counter only needs to reach MAX_REROLL; keep at least one bit.
  localparam int RW = (MAX_REROLL < 1) ? 1 : $clog2(MAX_REROLL + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [RW-1:0] MAX_RR  = RW'(MAX_REROLL);

  logic [4:0]    mem_q [DEPTH];
  logic [4:0]    mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    last_q, last_d;
  logic [RW-1:0] reroll_q, reroll_d;

  logic          code_ok;
  logic          pop_eff;
  logic          space;
  logic          push;
  logic [PW-1:0] rd_next;

  // Only the seven tetromino codes are legal; everything else is noise.
  always_comb begin
    code_ok = 1'b0;
    case (rand_piece)
      5'd1, 5'd3, 5'd7, 5'd11, 5'd12, 5'd14, 5'd18: code_ok = 1'b1;
      default:                                       code_ok = 1'b0;
    endcase
  end

  // Candidate filtering, push/pop and pointer/count bookkeeping.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    reroll_d = reroll_q;
    push     = 1'b0;

    pop_eff = pop && (count_q != '0);
    // A pop in the same cycle frees the head slot, so a full queue can still take a piece.
    space   = (count_q != DEPTH_C) || pop_eff;

    // Filter state only moves when the candidate could actually be stored.
    if (space && code_ok) begin
      if ((rand_piece == last_q) && (reroll_q < MAX_RR)) begin
        reroll_d = reroll_q + RW'(1);
      end else begin
        push     = 1'b1;
        last_d   = rand_piece;
        reroll_d = '0;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = rand_piece;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_eff) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop_eff})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset clears storage so the outputs read back as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      reroll_q <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
      reroll_q <= reroll_d;
    end
  end

  // Head and preview are read straight from the registered FIFO state.
  always_comb begin
    rd_next       = rd_ptr_q + PW'(1);
    piece_valid   = (count_q != '0);
    preview_valid = (count_q >= CW'(2));
    piece         = piece_valid ? mem_q[rd_ptr_q] : 5'd0;
    preview       = preview_valid ? mem_q[rd_next] : 5'd0;
    count         = count_q;
    full          = (count_q == DEPTH_C);
  end

endmodule
